// File: rtl/int_arbiter_if.sv
// -----------------------------------------------------------------------------
// int_arbiter_if
// Bundle of the interrupt source, arbitration and trap handshake signals that
// connect int_arbiter to the interrupt lines and the trap unit.
//
// Parameters : NSRC  - number of interrupt sources
//              PRIOW - priority width
// Modports   : slave  - the arbiter (consumes sources/controls, drives results)
//              master - the surrounding logic (drives sources/controls)
// Signals    : IntSrc/IntEdge/IntEn/IntPrio/Threshold/GlobalEn - source side
//              TakenM/ReturnM                                  - trap unit
//              IntReqM/IntIdM/IntPrioM                         - request
//              PendingM/CurLevel/NestOvf                       - status
// -----------------------------------------------------------------------------
interface int_arbiter_if #(
  parameter int NSRC  = 16,
  parameter int PRIOW = 3
);
  localparam int IDW = $clog2(NSRC);

  logic [NSRC-1:0]       IntSrc;
  logic [NSRC-1:0]       IntEdge;
  logic [NSRC-1:0]       IntEn;
  logic [NSRC*PRIOW-1:0] IntPrio;
  logic [PRIOW-1:0]      Threshold;
  logic                  GlobalEn;
  logic                  TakenM;
  logic                  ReturnM;
  logic                  IntReqM;
  logic [IDW-1:0]        IntIdM;
  logic [PRIOW-1:0]      IntPrioM;
  logic [NSRC-1:0]       PendingM;
  logic [PRIOW-1:0]      CurLevel;
  logic                  NestOvf;

  modport slave (
    input  IntSrc, IntEdge, IntEn, IntPrio, Threshold, GlobalEn, TakenM, ReturnM,
    output IntReqM, IntIdM, IntPrioM, PendingM, CurLevel, NestOvf
  );

  modport master (
    output IntSrc, IntEdge, IntEn, IntPrio, Threshold, GlobalEn, TakenM, ReturnM,
    input  IntReqM, IntIdM, IntPrioM, PendingM, CurLevel, NestOvf
  );
endinterface

// File: rtl/int_arbiter.sv
// -----------------------------------------------------------------------------
// int_arbiter
// Interrupt aggregation and prioritisation unit in front of the trap logic.
// Latches level/edge sources, selects the highest-priority enabled pending
// source above max(Threshold, CurLevel) (ties to lowest index) and presents it
// on a registered request. A take (TakenM while IntReqM) clears an edge
// source's pending bit and, with nesting, raises CurLevel.
//
// Optional feature: define INTARB_NEST_EN to build the DEPTH-entry level stack
// (preemptive nesting, ReturnM pops, NestOvf on push into a full stack).
// Without it CurLevel is 0, ReturnM is ignored and NestOvf is 0.
//
// Ports : clk   - core clock
//         reset - synchronous, active-high reset
//         bus   - int_arbiter_if.slave (sources, controls, request, status)
// Parameters NSRC/PRIOW must match those of the connected interface.
// -----------------------------------------------------------------------------
module int_arbiter #(
  parameter int NSRC  = 16,
  parameter int PRIOW = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  int_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NSRC);

  logic [NSRC-1:0]  r_src_q;
  logic [NSRC-1:0]  r_pend;
  logic             r_req;
  logic [IDW-1:0]   r_id;
  logic [PRIOW-1:0] r_prio;

  logic             w_take;
  logic [NSRC-1:0]  w_set;
  logic [NSRC-1:0]  w_clr;
  logic [NSRC-1:0]  w_pend_next;
  logic [NSRC-1:0]  w_cand;
  logic [PRIOW-1:0] w_prio [NSRC];
  logic [PRIOW-1:0] w_cur_next;
  logic [PRIOW-1:0] w_floor;
  logic             w_win_found;
  logic [IDW-1:0]   w_win_id;
  logic [PRIOW-1:0] w_win_prio;

  // TakenM only counts against a request actually being presented.
  assign w_take = bus.TakenM & r_req;

  // Candidates must beat both the software threshold and the running level.
  assign w_floor = (bus.Threshold > w_cur_next) ? bus.Threshold : w_cur_next;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_prio[gi] = bus.IntPrio[gi*PRIOW +: PRIOW];
      assign w_set[gi]  = bus.IntSrc[gi] & ~r_src_q[gi];
      assign w_clr[gi]  = w_take & bus.IntEdge[gi] & (r_id == IDW'(gi));
      // Edge: sticky latch, a new edge beats a coinciding take clear.
      // Level: simply the registered line.
      assign w_pend_next[gi] = bus.IntEdge[gi] ? (w_set[gi] | (r_pend[gi] & ~w_clr[gi]))
                                               : bus.IntSrc[gi];
      assign w_cand[gi] = w_pend_next[gi] & bus.IntEn[gi] & bus.GlobalEn &
                          (w_prio[gi] > w_floor);
    end
  endgenerate

  // Ascending scan with strict '>' keeps the lowest index on a priority tie.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_win_prio  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_cand[i] && (!w_win_found || (w_prio[i] > w_win_prio))) begin
        w_win_found = 1'b1;
        w_win_id    = IDW'(i);
        w_win_prio  = w_prio[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_q <= '1;  // lines already high at release are not edges
      r_pend  <= '0;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_prio  <= '0;
    end else begin
      r_src_q <= bus.IntSrc;
      r_pend  <= w_pend_next;
      r_req   <= w_win_found;
      r_id    <= w_win_id;
      r_prio  <= w_win_prio;
    end
  end

`ifdef INTARB_NEST_EN
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PRIOW-1:0] r_stack [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [PRIOW-1:0] r_cur;
  logic             r_ovf;
  logic             w_full;
  logic [IDXW-1:0]  w_top_idx;
  logic [IDXW-1:0]  w_push_idx;

  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_top_idx  = IDXW'(r_sp - 1'b1);
  assign w_push_idx = IDXW'(r_sp);

  // Take has precedence over a same-cycle return; popping empty yields 0.
  always_comb begin
    w_cur_next = r_cur;
    if (w_take) begin
      w_cur_next = r_prio;
    end else if (bus.ReturnM) begin
      w_cur_next = (r_sp == '0) ? '0 : r_stack[w_top_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cur <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cur <= w_cur_next;
      if (w_take) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_sp <= r_sp + 1'b1;
        end
      end else if (bus.ReturnM && (r_sp != '0)) begin
        r_sp <= r_sp - 1'b1;
      end
    end
  end

  // Stack storage needs no reset: the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && w_take && !w_full) begin
      r_stack[w_push_idx] <= r_cur;
    end
  end

  assign bus.CurLevel = r_cur;
  assign bus.NestOvf  = r_ovf;
`else
  localparam int unused_depth = DEPTH;
  logic w_unused_ret;

  assign w_unused_ret = bus.ReturnM;
  assign w_cur_next   = '0;
  assign bus.CurLevel = '0;
  assign bus.NestOvf  = 1'b0;
`endif

  assign bus.IntReqM  = r_req;
  assign bus.IntIdM   = r_id;
  assign bus.IntPrioM = r_prio;
  assign bus.PendingM = r_pend;
endmodule

// File: tb/tb_int_arbiter.sv
// -----------------------------------------------------------------------------
// tb_int_arbiter
// Self-checking bench for int_arbiter (NSRC=16, PRIOW=3, DEPTH=4). A
// behavioural model predicts every cycle's outputs; predictions are queued
// when stimulus is applied and compared once the DUT has clocked. Directed
// scenarios are followed by a randomised phase. Works with and without
// INTARB_NEST_EN.
// -----------------------------------------------------------------------------
module tb_int_arbiter;
  localparam int NSRC  = 16;
  localparam int PRIOW = 3;
  localparam int DEPTH = 4;
  localparam int PMAX  = (1 << PRIOW) - 1;
`ifdef INTARB_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  typedef struct {
    logic            req;
    logic [3:0]      id;
    logic [2:0]      prio;
    logic [15:0]     pend;
    logic [2:0]      cur;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cyc = 0;
  exp_t sb_q[$];

  // model state
  logic [15:0] m_pend;
  logic [15:0] m_srcq;
  int          m_cur;
  int          m_stk [DEPTH];
  int          m_sp;
  logic        m_ovf;
  logic        m_req;
  int          m_id;
  int          m_prio;

  always #5 clk = ~clk;

  int_arbiter_if #(.NSRC(NSRC), .PRIOW(PRIOW)) bus ();

  int_arbiter #(.NSRC(NSRC), .PRIOW(PRIOW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n_cyc);
    end
  endtask

  function automatic int prio_of(input int i);
    logic [2:0] p;
    p = bus.IntPrio[i*PRIOW +: PRIOW];
    return int'(p);
  endfunction

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_step(output exp_t e);
    logic [15:0] np;
    int          ncur;
    int          floor;
    bit          take;
    if (reset) begin
      m_pend = '0; m_srcq = '1; m_cur = 0; m_sp = 0; m_ovf = 1'b0;
      m_req = 1'b0; m_id = 0; m_prio = 0;
    end else begin
      take = bus.TakenM && m_req;
      for (int i = 0; i < NSRC; i++) begin
        if (bus.IntEdge[i]) begin
          if (bus.IntSrc[i] && !m_srcq[i]) np[i] = 1'b1;
          else if (take && m_id == i)      np[i] = 1'b0;
          else                             np[i] = m_pend[i];
        end else begin
          np[i] = bus.IntSrc[i];
        end
      end
      ncur = m_cur;
      if (NEST) begin
        if (take) begin
          if (m_sp < DEPTH) begin
            m_stk[m_sp] = m_cur;
            m_sp++;
          end else begin
            m_ovf = 1'b1;
          end
          ncur = m_prio;
        end else if (bus.ReturnM) begin
          if (m_sp == 0) ncur = 0;
          else begin
            m_sp--;
            ncur = m_stk[m_sp];
          end
        end
      end
      floor = (int'(bus.Threshold) > ncur) ? int'(bus.Threshold) : ncur;
      m_req = 1'b0; m_id = 0; m_prio = 0;
      // search from the top priority level downwards, lowest index first
      if (bus.GlobalEn) begin
        for (int p = PMAX; p > floor && !m_req; p--) begin
          for (int i = 0; i < NSRC && !m_req; i++) begin
            if (np[i] && bus.IntEn[i] && prio_of(i) == p) begin
              m_req = 1'b1; m_id = i; m_prio = p;
            end
          end
        end
      end
      m_srcq = bus.IntSrc;
      m_pend = np;
      m_cur  = ncur;
    end
    e.req  = m_req;
    e.id   = m_id[3:0];
    e.prio = m_prio[2:0];
    e.pend = m_pend;
    e.cur  = m_cur[2:0];
    e.ovf  = m_ovf;
  endtask

  task automatic step();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
    e = sb_q.pop_front();
    check_val("req",  bus.IntReqM,  e.req);
    check_val("id",   bus.IntIdM,   e.id);
    check_val("prio", bus.IntPrioM, e.prio);
    check_val("pend", bus.PendingM, e.pend);
    check_val("cur",  bus.CurLevel, e.cur);
    check_val("ovf",  bus.NestOvf,  e.ovf);
    $display("cyc %0d rst=%0b src=%h tk=%0b rt=%0b | req=%0b id=%0d pr=%0d pend=%h cur=%0d ovf=%0b",
             n_cyc, reset, bus.IntSrc, bus.TakenM, bus.ReturnM, bus.IntReqM,
             bus.IntIdM, bus.IntPrioM, bus.PendingM, bus.CurLevel, bus.NestOvf);
  endtask

  task automatic clear_inputs();
    bus.IntSrc = '0; bus.IntEdge = '0; bus.IntEn = '1; bus.IntPrio = '0;
    bus.Threshold = '0; bus.GlobalEn = 1'b1; bus.TakenM = 1'b0; bus.ReturnM = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic set_src(input int s, input bit edge_mode, input int p);
    bus.IntEdge[s] = edge_mode;
    bus.IntPrio[s*PRIOW +: PRIOW] = p[2:0];
  endtask

  task automatic take();
    bus.TakenM = 1'b1;
    step();
    bus.TakenM = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    check_val("rst_req",  bus.IntReqM,  0);
    check_val("rst_pend", bus.PendingM, 0);
    check_val("rst_cur",  bus.CurLevel, 0);

    // edge latch and take
    do_reset();
    set_src(5, 1'b1, 3);
    step();
    bus.IntSrc[5] = 1'b1;
    step();
    check_val("edge_req",  bus.IntReqM,  1);
    check_val("edge_id",   bus.IntIdM,   5);
    check_val("edge_prio", bus.IntPrioM, 3);
    bus.IntSrc[5] = 1'b0;
    take();
    check_val("edge_clr", bus.PendingM[5], 0);
    check_val("edge_req0", bus.IntReqM, 0);
    check_val("edge_cur", bus.CurLevel, NEST ? 3 : 0);

    // priority and tie-break
    do_reset();
    set_src(2, 1'b0, 4); set_src(9, 1'b0, 4); set_src(12, 1'b0, 6);
    bus.IntSrc[2] = 1'b1; bus.IntSrc[9] = 1'b1; bus.IntSrc[12] = 1'b1;
    step();
    check_val("tie_hi", bus.IntIdM, 12);
    bus.IntSrc[12] = 1'b0;
    step();
    check_val("tie_lo", bus.IntIdM, 2);

    // threshold and global masking
    do_reset();
    set_src(1, 1'b0, 2);
    bus.IntSrc[1] = 1'b1;
    bus.Threshold = 3'd2;
    step();
    step();
    check_val("thr_block", bus.IntReqM, 0);
    bus.Threshold = 3'd1;
    step();
    check_val("thr_pass", bus.IntReqM, 1);
    check_val("thr_id",   bus.IntIdM,  1);
    bus.GlobalEn = 1'b0;
    step();
    check_val("gen_mask", bus.IntReqM, 0);
    check_val("gen_pend", bus.PendingM[1], 1);

    // nesting
    do_reset();
    set_src(3, 1'b1, 2);
    step();
    bus.IntSrc[3] = 1'b1;
    step();
    bus.IntSrc[3] = 1'b0;
    take();
    check_val("nest_cur2", bus.CurLevel, NEST ? 2 : 0);
    set_src(4, 1'b0, 2);
    bus.IntSrc[4] = 1'b1;
    step();
    check_val("nest_block", bus.IntReqM, NEST ? 0 : 1);
    set_src(6, 1'b0, 5);
    bus.IntSrc[6] = 1'b1;
    step();
    check_val("nest_pre_id", bus.IntIdM, 6);
    take();
    check_val("nest_cur5", bus.CurLevel, NEST ? 5 : 0);
    bus.IntSrc[4] = 1'b0; bus.IntSrc[6] = 1'b0;
    bus.ReturnM = 1'b1;
    step();
    check_val("ret_cur2", bus.CurLevel, NEST ? 2 : 0);
    step();
    check_val("ret_cur0", bus.CurLevel, 0);
    step();
    check_val("ret_empty", bus.CurLevel, 0);
    bus.ReturnM = 1'b0;

    // overflow: five strictly increasing takes into a four-deep stack
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_src(7 + k, 1'b1, k + 1);
      step();
      bus.IntSrc[7 + k] = 1'b1;
      step();
      check_val("ovf_id", bus.IntIdM, 7 + k);
      bus.IntSrc[7 + k] = 1'b0;
      take();
      check_val("ovf_flag", bus.NestOvf, (NEST && k == 4) ? 1 : 0);
    end
    check_val("ovf_cur", bus.CurLevel, NEST ? 5 : 0);
    bus.ReturnM = 1'b1;
    step();
    check_val("ovf_pop", bus.CurLevel, NEST ? 3 : 0);
    bus.ReturnM = 1'b0;

    // take and return in the same cycle: push only
    do_reset();
    set_src(10, 1'b1, 3);
    step();
    bus.IntSrc[10] = 1'b1;
    step();
    bus.IntSrc[10] = 1'b0;
    bus.ReturnM = 1'b1;
    take();
    bus.ReturnM = 1'b0;
    check_val("tkret_cur", bus.CurLevel, NEST ? 3 : 0);

    // new edge coinciding with its own take clear
    do_reset();
    set_src(13, 1'b1, 7);
    step();
    bus.IntSrc[13] = 1'b1;
    step();
    bus.IntSrc[13] = 1'b0;
    step();
    bus.IntSrc[13] = 1'b1;
    take();
    check_val("setwin", bus.PendingM[13], 1);
    bus.IntSrc[13] = 1'b0;

    // reset in the middle of a nested handler
    do_reset();
    set_src(3, 1'b1, 2);
    set_src(6, 1'b1, 5);
    set_src(0, 1'b1, 1);
    set_src(8, 1'b0, 1);
    step();
    bus.IntSrc[3] = 1'b1;
    step();
    bus.IntSrc[3] = 1'b0;
    take();
    bus.IntSrc[6] = 1'b1;
    step();
    bus.IntSrc[6] = 1'b0;
    take();
    bus.IntSrc[0] = 1'b1;
    bus.IntSrc[8] = 1'b1;
    step();
    check_val("mid_cur", bus.CurLevel, NEST ? 5 : 0);
    reset = 1'b1;
    step();
    check_val("mid_req",  bus.IntReqM,  0);
    check_val("mid_pend", bus.PendingM, 0);
    check_val("mid_cur0", bus.CurLevel, 0);
    reset = 1'b0;
    step();
    check_val("mid_noedge", bus.PendingM[0], 0);
    bus.IntSrc = '0;
    bus.ReturnM = 1'b1;
    step();
    check_val("mid_stack", bus.CurLevel, 0);
    bus.ReturnM = 1'b0;

    // randomised traffic
    do_reset();
    bus.IntEdge = 16'($urandom());
    bus.IntPrio = 48'({$urandom(), $urandom()});
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        bus.IntEdge = 16'($urandom());
        bus.IntPrio = 48'({$urandom(), $urandom()});
      end
      bus.IntSrc    = 16'($urandom() & $urandom());
      bus.IntEn     = 16'($urandom() | $urandom());
      bus.Threshold = 3'($urandom_range(0, 3));
      bus.GlobalEn  = ($urandom_range(0, 9) != 0);
      bus.TakenM    = ($urandom_range(0, 2) != 0);
      bus.ReturnM   = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
